// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM encoding, oversampling ratio and 8N1 frame constants
// used by both the TX and RX paths.
package uart_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } tx_state_e;

   localparam int unsigned OVERSAMPLE       = 16;
   localparam int unsigned FRAME_START_BITS = 1;
   localparam int unsigned FRAME_DATA_BITS  = 8;
   localparam int unsigned FRAME_STOP_BITS  = 1;

   // Baud ticks spent on one frame: start plus data bits at OVERSAMPLE each, then the stop bit.
   function automatic int unsigned frame_ticks(input int unsigned data_bits,
                                               input int unsigned sb_tick);
      return (FRAME_START_BITS + data_bits) * OVERSAMPLE + sb_tick;
   endfunction

endpackage

// File: rtl/uart_tx_burst_if.sv
// Debug-unit side of the UART TX burst engine: byte push, burst control, baud tick and status.
interface uart_tx_burst_if #(
   parameter int unsigned NB_UART_DATA = 8,
   parameter int unsigned NB_UART_ADDR = 5
);

   logic                    i_wr;
   logic [NB_UART_DATA-1:0] i_wdata;
   logic                    i_tx_start;
   logic [NB_UART_ADDR-1:0] i_wsize;
   logic                    i_tick;
   logic                    o_tx;
   logic                    o_tx_done;
   logic                    o_busy;
   logic                    o_full;
   logic                    o_empty;
   logic [NB_UART_ADDR:0]   o_count;

   modport master (
      output i_wr, i_wdata, i_tx_start, i_wsize, i_tick,
      input  o_tx, o_tx_done, o_busy, o_full, o_empty, o_count
   );

   modport slave (
      input  i_wr, i_wdata, i_tx_start, i_wsize, i_tick,
      output o_tx, o_tx_done, o_busy, o_full, o_empty, o_count
   );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO holding bytes queued for transmission; writes while full are dropped and
// reads while empty are ignored.
module uart_tx_fifo #(
   parameter int unsigned DataW = 8,
   parameter int unsigned AddrW = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wr_i,
   input  logic [DataW-1:0] wdata_i,
   input  logic             rd_i,
   output logic [DataW-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AddrW:0]   count_o
);

   localparam int unsigned Depth = 2 ** AddrW;

   logic [DataW-1:0] mem_q [Depth];
   logic [AddrW-1:0] wptr_q, rptr_q;
   logic [AddrW:0]   count_q;
   logic             push, pop;

   assign full_o  = (count_q == (AddrW + 1)'(Depth));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rptr_q];
   assign push    = wr_i && !full_o;
   assign pop     = rd_i && !empty_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         unique case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset; only the pointers and occupancy define validity.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wptr_q] <= wdata_i;
   end

endmodule

// File: rtl/uart_tx_burst.sv
// UART transmitter that serialises a burst of queued bytes as back-to-back 8N1 frames,
// paced by a shared 16x oversampled baud tick.
module uart_tx_burst
   import uart_pkg::*;
#(
   parameter int unsigned NB_UART_DATA = 8,
   parameter int unsigned NB_UART_ADDR = 5,
   parameter int unsigned SB_TICK      = 16
) (
   input logic          clk,
   input logic          i_rst,
   uart_tx_burst_if.slave bus
);

   localparam int unsigned TickW = $clog2(OVERSAMPLE);
   localparam int unsigned IdxW  = $clog2(NB_UART_DATA);
   localparam int unsigned CntW  = NB_UART_ADDR + 1;

   localparam logic [TickW-1:0] BitLast  = TickW'(OVERSAMPLE - 1);
   localparam logic [TickW-1:0] StopLast = TickW'(SB_TICK - 1);
   localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NB_UART_DATA - 1);

   tx_state_e               state_q;
   logic [TickW-1:0]        tick_cnt_q;
   logic [IdxW-1:0]         bit_idx_q;
   logic [NB_UART_DATA-1:0] shreg_q;
   logic [CntW-1:0]         remaining_q;
   logic                    tx_q;
   logic                    done_q;

   logic [NB_UART_DATA-1:0] fifo_rdata;
   logic [CntW-1:0]         fifo_count;
   logic                    fifo_full, fifo_empty;
   logic                    bit_end, stop_end, launch, next_byte, pop;
   logic [CntW-1:0]         wsize_ext, burst_len;

   uart_tx_fifo #(
      .DataW (NB_UART_DATA),
      .AddrW (NB_UART_ADDR)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (i_rst),
      .wr_i    (bus.i_wr),
      .wdata_i (bus.i_wdata),
      .rd_i    (pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      bit_end   = bus.i_tick && (tick_cnt_q == BitLast);
      stop_end  = bus.i_tick && (tick_cnt_q == StopLast);
      launch    = (state_q == StIdle) && bus.i_tx_start && !fifo_empty;
      next_byte = (state_q == StStop) && stop_end && (remaining_q != CntW'(1));
      pop       = launch || next_byte;
      wsize_ext = CntW'(bus.i_wsize);
      // A zero or oversized request is clamped to what is buffered right now.
      burst_len = ((wsize_ext == '0) || (wsize_ext > fifo_count)) ? fifo_count : wsize_ext;
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q     <= StIdle;
         tick_cnt_q  <= '0;
         bit_idx_q   <= '0;
         shreg_q     <= '0;
         remaining_q <= '0;
         tx_q        <= 1'b1;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (launch) begin
                  remaining_q <= burst_len;
                  shreg_q     <= fifo_rdata;
                  tx_q        <= 1'b0;
                  tick_cnt_q  <= '0;
                  state_q     <= StStart;
               end
            end
            StStart: begin
               if (bit_end) begin
                  tick_cnt_q <= '0;
                  bit_idx_q  <= '0;
                  tx_q       <= shreg_q[0];
                  state_q    <= StData;
               end else if (bus.i_tick) begin
                  tick_cnt_q <= tick_cnt_q + 1'b1;
               end
            end
            StData: begin
               if (bit_end) begin
                  tick_cnt_q <= '0;
                  if (bit_idx_q == IdxLast) begin
                     tx_q    <= 1'b1;
                     state_q <= StStop;
                  end else begin
                     shreg_q   <= shreg_q >> 1;
                     tx_q      <= shreg_q[1];
                     bit_idx_q <= bit_idx_q + 1'b1;
                  end
               end else if (bus.i_tick) begin
                  tick_cnt_q <= tick_cnt_q + 1'b1;
               end
            end
            StStop: begin
               if (stop_end) begin
                  tick_cnt_q  <= '0;
                  remaining_q <= remaining_q - 1'b1;
                  if (next_byte) begin
                     shreg_q <= fifo_rdata;
                     tx_q    <= 1'b0;
                     state_q <= StStart;
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= StIdle;
                  end
               end else if (bus.i_tick) begin
                  tick_cnt_q <= tick_cnt_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.o_tx      = tx_q;
   assign bus.o_tx_done = done_q;
   assign bus.o_busy    = (state_q != StIdle);
   assign bus.o_full    = fifo_full;
   assign bus.o_empty   = fifo_empty;
   assign bus.o_count   = fifo_count;

endmodule

// File: tb/tb_uart_tx_burst.sv
// Directed bench for uart_tx_burst: decodes frames from o_tx tick by tick and checks the
// burst, FIFO and reset behaviour against hand-computed values.
module tb_uart_tx_burst;

   localparam int unsigned NbD = 8;
   localparam int unsigned NbA = 5;
   localparam int unsigned Sb  = 16;
   localparam int FrameTicks   = (1 + 8) * 16 + 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_tx_burst_if #(.NB_UART_DATA(NbD), .NB_UART_ADDR(NbA)) bus ();

   uart_tx_burst #(
      .NB_UART_DATA (NbD),
      .NB_UART_ADDR (NbA),
      .SB_TICK      (Sb)
   ) dut (
      .clk   (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int   vectors = 0, miscompares = 0;
   int   done_cnt = 0, glitches = 0, cell_bad = 0;
   logic tick_en = 1'b0;
   int   div = 0;
   logic [7:0] exp_q [$];

   // Baud tick at 1/3 duty, changed away from both clock edges.
   always @(posedge clk) begin
      #2;
      if (tick_en) begin
         div = (div == 2) ? 0 : div + 1;
         bus.i_tick = (div == 0);
      end else begin
         bus.i_tick = 1'b0;
      end
   end

   // o_tx may only move on a tick edge once a burst is running.
   logic prev_tx = 1'b1, prev_busy = 1'b0, prev_tick = 1'b0;
   always @(negedge clk) begin
      if (bus.o_tx_done === 1'b1) done_cnt++;
      if (!rst && prev_busy && (bus.o_tx !== prev_tx) && !prev_tick) glitches++;
      prev_tx   = bus.o_tx;
      prev_busy = bus.o_busy;
      prev_tick = bus.i_tick;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      @(negedge clk);
      bus.i_wr    = 1'b1;
      bus.i_wdata = b;
      @(negedge clk);
      bus.i_wr    = 1'b0;
   endtask

   task automatic pulse_start(input logic [4:0] ws);
      @(negedge clk);
      bus.i_wsize    = ws;
      bus.i_tx_start = 1'b1;
      @(negedge clk);
      bus.i_tx_start = 1'b0;
   endtask

   // Returns at the negedge just before the last stop-bit tick edge.
   task automatic rx_frame(output logic [7:0] data, output logic ok, output int gap);
      int   k, n;
      logic cellv;
      ok = 1'b0; data = '0; gap = 0; k = 0; n = 0; cellv = 1'b0;
      while (bus.o_tx !== 1'b0 && gap < 300) begin
         @(negedge clk);
         gap++;
      end
      if (bus.o_tx !== 1'b0) return;
      forever begin
         if (bus.i_tick === 1'b1) begin
            if (k % 16 == 0) begin
               cellv = bus.o_tx;
               if (k == 0 && cellv !== 1'b0) cell_bad++;
               if (k == 144 && cellv !== 1'b1) cell_bad++;
            end else if (bus.o_tx !== cellv) begin
               cell_bad++;
            end
            if (k % 16 == 7 && k / 16 >= 1 && k / 16 <= 8) data[k/16-1] = bus.o_tx;
            k++;
         end
         if (k == FrameTicks || n >= 2000) break;
         @(negedge clk);
         n++;
      end
      ok = (k == FrameTicks);
   endtask

   task automatic rx_burst(input string tag, input int nframes);
      logic [7:0] d;
      logic       ok;
      int         gap, d0;
      d0 = done_cnt;
      for (int i = 0; i < nframes; i++) begin
         rx_frame(d, ok, gap);
         chk({tag, "_frame_ok"}, 32'(ok), 32'd1);
         if (!ok) break;
         chk({tag, "_data"}, 32'(d), 32'(exp_q.pop_front()));
         if (i > 0) chk({tag, "_back_to_back"}, gap, 32'd1);
      end
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(bus.o_tx_done), 32'd1);
      chk({tag, "_idle_after"}, 32'(bus.o_busy), 32'd0);
      repeat (3) @(negedge clk);
      chk({tag, "_done_once"}, done_cnt - d0, 32'd1);
   endtask

   initial begin
      int d0;
      bus.i_wr = 1'b0; bus.i_wdata = '0; bus.i_tx_start = 1'b0; bus.i_wsize = '0;
      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(bus.o_tx), 32'd1);
      chk("rst_done", 32'(bus.o_tx_done), 32'd0);
      chk("rst_busy", 32'(bus.o_busy), 32'd0);
      chk("rst_full", 32'(bus.o_full), 32'd0);
      chk("rst_empty", 32'(bus.o_empty), 32'd1);
      chk("rst_count", 32'(bus.o_count), 32'd0);
      rst = 1'b0;
      tick_en = 1'b1;

      // Partial burst of two out of three bytes.
      push(8'h55); push(8'hA3); push(8'h0F);
      chk("t1_count", 32'(bus.o_count), 32'd3);
      exp_q.push_back(8'h55); exp_q.push_back(8'hA3);
      pulse_start(5'd2);
      chk("t1_latency_tx", 32'(bus.o_tx), 32'd0);
      chk("t1_busy", 32'(bus.o_busy), 32'd1);
      chk("t1_count_pop", 32'(bus.o_count), 32'd2);
      rx_burst("t1", 2);
      chk("t1_count_after", 32'(bus.o_count), 32'd1);
      exp_q.push_back(8'h0F);
      pulse_start(5'd0);
      rx_burst("t1_drain", 1);
      chk("t1_empty", 32'(bus.o_empty), 32'd1);

      // Whole-FIFO bursts via wsize=0 and a clamped oversize request.
      push(8'h11); push(8'h22); push(8'h33);
      exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
      pulse_start(5'd0);
      rx_burst("t2_ws0", 3);
      chk("t2_ws0_empty", 32'(bus.o_empty), 32'd1);
      push(8'h44); push(8'h5C); push(8'hE6);
      exp_q.push_back(8'h44); exp_q.push_back(8'h5C); exp_q.push_back(8'hE6);
      pulse_start(5'd7);
      rx_burst("t2_ws7", 3);
      chk("t2_ws7_empty", 32'(bus.o_empty), 32'd1);
      chk("t2_ws7_count", 32'(bus.o_count), 32'd0);

      // Start on an empty FIFO is a no-op.
      d0 = done_cnt;
      pulse_start(5'd0);
      chk("t5_empty_busy", 32'(bus.o_busy), 32'd0);
      chk("t5_empty_tx", 32'(bus.o_tx), 32'd1);
      repeat (5) @(negedge clk);
      chk("t5_empty_nodone", done_cnt - d0, 32'd0);

      // Second start mid-burst is dropped, not queued.
      push(8'h81); push(8'h7E);
      exp_q.push_back(8'h81);
      pulse_start(5'd1);
      fork
         rx_burst("t5_ignore", 1);
         begin
            repeat (80) @(negedge clk);
            pulse_start(5'd0);
         end
      join
      chk("t5_ignore_count", 32'(bus.o_count), 32'd1);
      d0 = done_cnt;
      repeat (600) @(negedge clk);
      chk("t5_ignore_busy", 32'(bus.o_busy), 32'd0);
      chk("t5_ignore_nodone", done_cnt - d0, 32'd0);

      // Push and launch-pop on the same edge.
      @(negedge clk);
      bus.i_wr = 1'b1; bus.i_wdata = 8'h5A; bus.i_wsize = 5'd1; bus.i_tx_start = 1'b1;
      @(negedge clk);
      bus.i_wr = 1'b0; bus.i_tx_start = 1'b0;
      chk("t5_pushpop_count", 32'(bus.o_count), 32'd1);
      chk("t5_pushpop_tx", 32'(bus.o_tx), 32'd0);
      exp_q.push_back(8'h7E);
      rx_burst("t5_pushpop", 1);
      exp_q.push_back(8'h5A);
      pulse_start(5'd0);
      rx_burst("t5_drain", 1);

      // Fill past capacity; the 33rd byte is dropped.
      for (int i = 0; i < 33; i++) begin
         push(8'(i));
         if (i == 30) chk("t3_not_full", 32'(bus.o_full), 32'd0);
         if (i == 31) chk("t3_full", 32'(bus.o_full), 32'd1);
         if (i < 32) exp_q.push_back(8'(i));
      end
      chk("t3_count", 32'(bus.o_count), 32'd32);
      chk("t3_full_after_drop", 32'(bus.o_full), 32'd1);
      pulse_start(5'd0);
      rx_burst("t3", 32);
      chk("t3_empty", 32'(bus.o_empty), 32'd1);

      // Reset in the middle of a data bit.
      push(8'hC3); push(8'h99);
      pulse_start(5'd1);
      repeat (165) @(negedge clk);
      chk("t4_busy_before", 32'(bus.o_busy), 32'd1);
      chk("t4_tx_in_bit2", 32'(bus.o_tx), 32'd0);
      d0 = done_cnt;
      rst = 1'b1;
      @(negedge clk);
      chk("t4_tx", 32'(bus.o_tx), 32'd1);
      chk("t4_busy", 32'(bus.o_busy), 32'd0);
      chk("t4_count", 32'(bus.o_count), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (700) @(negedge clk);
      chk("t4_nodone", done_cnt - d0, 32'd0);
      chk("t4_tx_idle", 32'(bus.o_tx), 32'd1);

      chk("tick_aligned_edges", glitches, 32'd0);
      chk("bit_cells_16_ticks", cell_bad, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
